fp_task_dispatcher: RTL and testbench

- Parametrised command dispatcher between the UART command deframer and the I2C result writer.
- Accepts one floating-point task per handshake: opcode plus operands A and B.
- Issues the task to an external arithmetic unit (adder, subtractor or multiplier, any fixed or variable latency) and waits for the result, with a timeout.
- Emits a tagged response frame: operands, result and status.

---
 rtl/fp_dispatch_pkg.sv | 29 ++
 rtl/fp_dispatch_timer.sv | 38 +++
 rtl/fp_task_dispatcher.sv | 177 +++++++++++++++++
 tb/tb_fp_task_dispatcher.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_dispatch_pkg.sv
// fp_dispatch_pkg
// Shared definitions for the floating-point task dispatcher:
//   - opcode encodings carried on cmd_op / exe_op
//   - status encodings carried on rsp_status
//   - dispatcher FSM state type
//   - helper to classify an opcode as executable
package fp_dispatch_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ILLEGAL = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_ISSUE    = 2'b01,
        S_WAIT_RES = 2'b10,
        S_RESPOND  = 2'b11
    } state_t;

    function automatic logic is_legal_op(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/fp_dispatch_timer.sv
// fp_dispatch_timer
// Clear/enable cycle counter with an expiry flag for the dispatcher's
// result timeout.
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_clear    synchronous clear (takes priority over i_enable)
//   i_enable   count one per cycle
//   o_expired  high while enabled and the count has reached TIMEOUT-1;
//              never asserted when TIMEOUT is 0
module fp_dispatch_timer #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // At least one bit so TIMEOUT of 0 or 1 still elaborates.
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (TIMEOUT != 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/fp_task_dispatcher.sv
// fp_task_dispatcher
// Accepts one floating-point task per command handshake, issues it to an
// external arithmetic unit, waits (with timeout) for the one-cycle result
// strobe and presents a tagged response frame.
//   clk, reset                  clock / asynchronous active-high reset
//   cmd_valid/ready, cmd_op/a/b  command input (op 11 is reserved)
//   exe_valid/ready, exe_op/a/b  task issue to the arithmetic unit
//   res_valid, res_data          result strobe from the arithmetic unit
//   rsp_valid/ready, rsp_*       response frame (tag, status, a, b, result)
//   busy                         FSM not idle
//   done                         one-cycle pulse after each response handshake
module fp_task_dispatcher
    import fp_dispatch_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              exe_valid,
    input  logic              exe_ready,
    output logic [1:0]        exe_op,
    output logic [DATA_W-1:0] exe_a,
    output logic [DATA_W-1:0] exe_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [1:0]        rsp_status,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic [DATA_W-1:0] rsp_result,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic [1:0]        r_status;
    logic [TAG_W-1:0]  r_tag;
    logic              r_done;

    logic w_accept;
    logic w_legal;
    logic w_capture;
    logic w_timeout;
    logic w_rsp_hs;
    logic w_active;
    logic w_expired;

    assign w_active = (r_state == S_ISSUE) || (r_state == S_WAIT_RES);
    assign w_legal  = is_legal_op(cmd_op);

    // Counter sits at zero whenever no task is outstanding, so it is
    // already clear on the first ISSUE cycle.
    fp_dispatch_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_clear   (!w_active),
        .i_enable  (w_active),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_rsp_hs     = 1'b0;
        // reset gating keeps cmd_ready low while reset is held
        cmd_ready    = (r_state == S_IDLE) && !reset;
        exe_valid    = (r_state == S_ISSUE);
        rsp_valid    = (r_state == S_RESPOND);
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = w_legal ? S_ISSUE : S_RESPOND;
                end
            end
            S_ISSUE: begin
                // a result only counts once the unit has taken the task;
                // a result in the expiry cycle beats the timeout
                if (exe_ready && res_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RESPOND;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_RESPOND;
                end else if (exe_ready) begin
                    w_next_state = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (res_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RESPOND;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (rsp_ready) begin
                    w_rsp_hs     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_status <= ST_OK;
            r_tag    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_rsp_hs;
            if (w_accept) begin
                r_op     <= cmd_op;
                r_a      <= cmd_a;
                r_b      <= cmd_b;
                r_result <= '0;
                r_status <= w_legal ? ST_OK : ST_ILLEGAL;
            end
            if (w_capture) begin
                r_result <= res_data;
                r_status <= ST_OK;
            end
            if (w_timeout) begin
                r_result <= '0;
                r_status <= ST_TIMEOUT;
            end
            if (w_rsp_hs) begin
                r_tag <= r_tag + TAG_W'(1);
            end
        end
    end

    assign exe_op     = r_op;
    assign exe_a      = r_a;
    assign exe_b      = r_b;
    assign rsp_tag    = r_tag;
    assign rsp_status = r_status;
    assign rsp_a      = r_a;
    assign rsp_b      = r_b;
    assign rsp_result = r_result;
    assign done       = r_done;

endmodule

// File: tb/tb_fp_task_dispatcher.sv
// tb_fp_task_dispatcher
// Directed bench for fp_task_dispatcher (TIMEOUT=8, TAG_W=4). A response
// scoreboard plus per-cycle protocol rules check every cycle; directed
// literal checks pin latencies, tags and status values.
module tb_fp_task_dispatcher;
    import fp_dispatch_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 4;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic          exe_valid;
    logic          exe_ready = 1'b0;
    logic [1:0]    exe_op;
    logic [DW-1:0] exe_a;
    logic [DW-1:0] exe_b;
    logic          res_valid = 1'b0;
    logic [DW-1:0] res_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [TW-1:0] rsp_tag;
    logic [1:0]    rsp_status;
    logic [DW-1:0] rsp_a;
    logic [DW-1:0] rsp_b;
    logic [DW-1:0] rsp_result;
    logic          busy;
    logic          done;

    fp_task_dispatcher #(
        .DATA_W (DW),
        .TAG_W  (TW),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .exe_valid (exe_valid),
        .exe_ready (exe_ready),
        .exe_op    (exe_op),
        .exe_a     (exe_a),
        .exe_b     (exe_b),
        .res_valid (res_valid),
        .res_data  (res_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_tag   (rsp_tag),
        .rsp_status(rsp_status),
        .rsp_a     (rsp_a),
        .rsp_b     (rsp_b),
        .rsp_result(rsp_result),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- response model ----------------
    typedef struct packed {
        logic [1:0]    st;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
    } rsp_t;

    rsp_t exp_q[$];

    function automatic rsp_t mk(input logic [1:0] st, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input logic [DW-1:0] res);
        rsp_t r;
        r.st  = st;
        r.a   = a;
        r.b   = b;
        r.res = res;
        return r;
    endfunction

    // Tag is the count of response handshakes since reset, modulo 2^TW.
    // done must follow each handshake by exactly one cycle.
    initial begin
        int unsigned   m_tag;
        logic          m_done_due;
        logic          prev_hold;
        logic [1:0]    prev_op;
        logic [DW-1:0] prev_a;
        logic [DW-1:0] prev_b;
        rsp_t          h;
        m_tag      = 0;
        m_done_due = 1'b0;
        prev_hold  = 1'b0;
        prev_op    = '0;
        prev_a     = '0;
        prev_b     = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                m_tag      = 0;
                m_done_due = 1'b0;
                prev_hold  = 1'b0;
            end else begin
                chk("m_done", done, m_done_due);
                chk("m_busy_vs_ready", busy, !cmd_ready);
                if (prev_hold) begin
                    chk("m_exe_hold_valid", exe_valid, 1'b1);
                    chk("m_exe_hold_op", exe_op, prev_op);
                    chk("m_exe_hold_a", exe_a, prev_a);
                    chk("m_exe_hold_b", exe_b, prev_b);
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("m_rsp_unexpected", rsp_valid, 1'b0);
                    end else begin
                        h = exp_q[0];
                        chk("m_rsp_tag", rsp_tag, m_tag % (1 << TW));
                        chk("m_rsp_status", rsp_status, h.st);
                        chk("m_rsp_a", rsp_a, h.a);
                        chk("m_rsp_b", rsp_b, h.b);
                        chk("m_rsp_result", rsp_result, h.res);
                    end
                end
                m_done_due = rsp_valid && rsp_ready;
                if (m_done_due) begin
                    if (exp_q.size() != 0) exp_q.pop_front();
                    m_tag++;
                end
                prev_hold = exe_valid && !exe_ready;
                prev_op   = exe_op;
                prev_a    = exe_a;
                prev_b    = exe_b;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int hs;
        int acc;
        int done_cnt;
        int start;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_exe_valid", exe_valid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_tag", rsp_tag, 4'h0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        tick();

        // ADD 1.5 + 2.25, unit answers 3 cycles after the exe handshake
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 32'h3FC00000; cmd_b = 32'h40100000;
        exp_q.push_back(mk(ST_OK, 32'h3FC00000, 32'h40100000, 32'h40700000));
        tick();
        cmd_valid = 1'b0;
        chk("add_exe_valid", exe_valid, 1'b1);
        chk("add_exe_op", exe_op, OP_ADD);
        chk("add_exe_a", exe_a, 32'h3FC00000);
        chk("add_exe_b", exe_b, 32'h40100000);
        chk("add_cmd_ready_low", cmd_ready, 1'b0);
        exe_ready = 1'b1;
        tick();
        hs = cyc;
        exe_ready = 1'b0;
        chk("add_exe_dropped", exe_valid, 1'b0);
        tick();
        tick();
        chk("add_no_rsp_yet", rsp_valid, 1'b0);
        res_valid = 1'b1; res_data = 32'h40700000;
        tick();
        res_valid = 1'b0; res_data = '0;
        // rsp_valid rises 3 edges after the handshake edge (cycle E+4)
        chk("add_rsp_latency", cyc - hs, 3);
        chk("add_rsp_valid", rsp_valid, 1'b1);
        chk("add_rsp_status", rsp_status, 2'b00);
        chk("add_rsp_result", rsp_result, 32'h40700000);
        chk("add_rsp_tag", rsp_tag, 4'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("add_done", done, 1'b1);
        chk("add_cmd_ready_again", cmd_ready, 1'b1);
        tick();

        // reserved opcode
        cmd_valid = 1'b1; cmd_op = OP_RSVD; cmd_a = 32'h3F800000; cmd_b = 32'h3F800000;
        exp_q.push_back(mk(ST_ILLEGAL, 32'h3F800000, 32'h3F800000, 32'h0));
        tick();
        cmd_valid = 1'b0;
        chk("ill_rsp_valid", rsp_valid, 1'b1);
        chk("ill_exe_valid", exe_valid, 1'b0);
        chk("ill_status", rsp_status, 2'b01);
        chk("ill_result", rsp_result, 32'h0);
        chk("ill_tag", rsp_tag, 4'h1);
        tick();
        chk("ill_exe_valid_hold", exe_valid, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("ill_done", done, 1'b1);

        // timeout: MUL accepted, result never strobed
        cmd_valid = 1'b1; cmd_op = OP_MUL; cmd_a = 32'h40000000; cmd_b = 32'h40400000;
        exp_q.push_back(mk(ST_TIMEOUT, 32'h40000000, 32'h40400000, 32'h0));
        tick();
        acc = cyc;
        cmd_valid = 1'b0;
        exe_ready = 1'b1;
        tick();
        exe_ready = 1'b0;
        while (!rsp_valid && (cyc - acc) < 30) tick();
        chk("to_latency", cyc - acc, TO);
        chk("to_status", rsp_status, 2'b10);
        chk("to_result", rsp_result, 32'h0);
        chk("to_exe_valid", exe_valid, 1'b0);
        chk("to_tag", rsp_tag, 4'h2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        res_valid = 1'b1; res_data = 32'hDEADBEEF;
        tick();
        res_valid = 1'b0; res_data = '0;
        chk("late_busy", busy, 1'b0);
        chk("late_rsp_valid", rsp_valid, 1'b0);
        cmd_valid = 1'b1; cmd_op = OP_SUB; cmd_a = 32'h40A00000; cmd_b = 32'h3F800000;
        exp_q.push_back(mk(ST_OK, 32'h40A00000, 32'h3F800000, 32'h40800000));
        tick();
        cmd_valid = 1'b0;
        exe_ready = 1'b1; res_valid = 1'b1; res_data = 32'h40800000;
        tick();
        exe_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        chk("after_to_status", rsp_status, 2'b00);
        chk("after_to_result", rsp_result, 32'h40800000);
        chk("after_to_tag", rsp_tag, 4'h3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // back-pressure on both sides
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 32'h11111111; cmd_b = 32'h22222222;
        exp_q.push_back(mk(ST_OK, 32'h11111111, 32'h22222222, 32'h33333333));
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_exe_valid", exe_valid, 1'b1);
            chk("stall_exe_a", exe_a, 32'h11111111);
            chk("stall_exe_b", exe_b, 32'h22222222);
            chk("stall_cmd_ready", cmd_ready, 1'b0);
            tick();
        end
        exe_ready = 1'b1; res_valid = 1'b1; res_data = 32'h33333333;
        tick();
        exe_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", rsp_valid, 1'b1);
            chk("stall_rsp_result", rsp_result, 32'h33333333);
            chk("stall_rsp_tag", rsp_tag, 4'h4);
            chk("stall_rsp_cmd_ready", cmd_ready, 1'b0);
            done_cnt += int'(done);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            done_cnt += int'(done);
            tick();
        end
        chk("stall_done_count", done_cnt, 1);

        // 17 back-to-back SUBs from a fresh reset with a zero-latency unit
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("b2b_rst_tag", rsp_tag, 4'h0);
        tick();
        exe_ready = 1'b1; res_valid = 1'b1; rsp_ready = 1'b1;
        start = cyc;
        for (int k = 0; k < 17; k++) begin
            cmd_valid = 1'b1; cmd_op = OP_SUB;
            cmd_a = DW'(k); cmd_b = DW'(k * 3); res_data = DW'(32'h1000 + k);
            exp_q.push_back(mk(ST_OK, DW'(k), DW'(k * 3), DW'(32'h1000 + k)));
            chk("b2b_cmd_ready", cmd_ready, 1'b1);
            tick();
            cmd_valid = 1'b0;
            tick();
            chk("b2b_rsp_valid", rsp_valid, 1'b1);
            chk("b2b_tag", rsp_tag, k % 16);
            tick();
            chk("b2b_done", done, 1'b1);
        end
        chk("b2b_cycles", cyc - start, 51);
        exe_ready = 1'b0; res_valid = 1'b0; rsp_ready = 1'b0; res_data = '0;
        tick();

        // asynchronous reset while waiting for a result
        cmd_valid = 1'b1; cmd_op = OP_MUL; cmd_a = 32'h5; cmd_b = 32'h6;
        tick();
        cmd_valid = 1'b0;
        exe_ready = 1'b1;
        tick();
        exe_ready = 1'b0;
        tick();
        chk("pre_rst_busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_cmd_ready", cmd_ready, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_exe_valid", exe_valid, 1'b0);
        chk("arst_exe_op", exe_op, 2'b00);
        chk("arst_exe_a", exe_a, 32'h0);
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        chk("arst_rsp_tag", rsp_tag, 4'h0);
        chk("arst_rsp_a", rsp_a, 32'h0);
        chk("arst_done", done, 1'b0);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_rel_cmd_ready", cmd_ready, 1'b1);
        chk("arst_rel_tag", rsp_tag, 4'h0);
        res_valid = 1'b1; res_data = 32'hBADBAD00;
        tick();
        res_valid = 1'b0; res_data = '0;
        chk("stale_busy", busy, 1'b0);
        chk("stale_rsp_valid", rsp_valid, 1'b0);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 32'h3F800000; cmd_b = 32'h3F800000;
        exp_q.push_back(mk(ST_OK, 32'h3F800000, 32'h3F800000, 32'h40000000));
        tick();
        cmd_valid = 1'b0;
        exe_ready = 1'b1; res_valid = 1'b1; res_data = 32'h40000000;
        tick();
        exe_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        chk("final_rsp_tag", rsp_tag, 4'h0);
        chk("final_rsp_result", rsp_result, 32'h40000000);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
